// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Pops row vectors from a show-ahead FIFO and feeds them into the left edge
// of a systolic array with a diagonal skew: lane i lags lane 0 by i cycles.
// One burst of num_rows vectors runs per start. When the FIFO runs empty,
// bubbles are inserted. At the end of the burst the skew pipe is flushed.
// When array_ready is low, every register holds its value.
//
// state | meaning
// IDLE  | waiting for start; injects bubbles
// FEED  | popping rows while the FIFO has data and the array is ready
// FLUSH | last row popped; pushing it through the remaining LANES-1 stages
// DONE  | last row fully on array_data; done pulse, back to IDLE next cycle
module systolic_skew_feeder #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int ROWS_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROWS_W-1:0]      num_rows,
    input  logic                   fifo_empty,
    input  logic [LANES*WIDTH-1:0] fifo_rdata,
    output logic                   fifo_rd_en,
    input  logic                   array_ready,
    output logic [LANES*WIDTH-1:0] array_data,
    output logic [LANES-1:0]       array_valid,
    output logic                   busy,
    output logic                   done
);

    // Flush counter only needs to hold LANES-1.
    localparam int FLUSH_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ROWS_W-1:0]   rows_left_q, rows_left_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                pop;
    logic                last_pop;

    assign pop        = (state_q == S_FEED) & ~fifo_empty & array_ready & ~rst;
    assign last_pop   = pop & (rows_left_q == ROWS_W'(1));
    assign fifo_rd_en = pop;
    assign busy       = busy_q;
    assign done       = done_q;

    // Next-state, row counter and flush down-counter decisions.
    always_comb begin
        state_d     = state_q;
        rows_left_d = rows_left_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_left_d = num_rows;
                    state_d     = (num_rows != '0) ? S_FEED : S_DONE;
                end
            end
            S_FEED: begin
                if (pop) begin
                    rows_left_d = rows_left_q - ROWS_W'(1);
                    if (last_pop) begin
                        if (LANES > 1) begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (array_ready) begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    if (flush_cnt_q == FLUSH_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Control registers; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rows_left_q <= '0;
            flush_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_left_q <= rows_left_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Lane i is an (i+1)-stage shift register of {valid, data}.
    // All lanes load stage 0 on the same cycle. The stage count gives the skew.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0]            valid_q, valid_d;
        logic [i:0][WIDTH-1:0] data_q, data_d;

        // Inject a popped element or a zero bubble, then shift, but only on advance.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (array_ready) begin
                valid_d[0] = pop;
                data_d[0]  = pop ? fifo_rdata[i*WIDTH +: WIDTH] : '0;
                for (int k = 1; k <= i; k++) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end

        // Skew stage registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign array_valid[i]               = valid_q[i];
        assign array_data[i*WIDTH +: WIDTH] = data_q[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (LANES=4, WIDTH=8).
// A small ring-buffer FIFO model supplies rows. Each cycle is driven and then
// checked against hand-computed expected outputs.
module tb_systolic_skew_feeder;

    localparam int LANES  = 4;
    localparam int WIDTH  = 8;
    localparam int ROWS_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [ROWS_W-1:0]      num_rows;
    logic                   fifo_empty;
    logic [LANES*WIDTH-1:0] fifo_rdata;
    logic                   fifo_rd_en;
    logic                   array_ready;
    logic [LANES*WIDTH-1:0] array_data;
    logic [LANES-1:0]       array_valid;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fifo_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty = 1'b0;
    logic        fifo_clr   = 1'b0;

    systolic_skew_feeder #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .ROWS_W(ROWS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rows   (num_rows),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .array_ready(array_ready),
        .array_data (array_data),
        .array_valid(array_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_empty = hold_empty || (wr_ptr == rd_ptr);
        fifo_rdata = fifo_mem[rd_ptr[3:0]];
    end

    always @(posedge clk) begin
        if (fifo_clr)
            rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty)
            rd_ptr <= rd_ptr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        fifo_mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_fifo();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    // Drive one cycle of inputs, check all outputs, then advance to the next cycle.
    task automatic cyc(input string tag, input logic st, input logic [15:0] nr,
                       input logic rdy, input logic hold, input logic rs,
                       input logic e_rd, input logic [3:0] e_valid,
                       input logic [31:0] e_data, input logic e_done, input logic e_busy);
        start       = st;
        num_rows    = nr;
        array_ready = rdy;
        hold_empty  = hold;
        rst         = rs;
        #1;
        chk($sformatf("%s rd_en", tag), {31'd0, fifo_rd_en}, {31'd0, e_rd});
        chk($sformatf("%s valid", tag), {28'd0, array_valid}, {28'd0, e_valid});
        chk($sformatf("%s data",  tag), array_data, e_data);
        chk($sformatf("%s done",  tag), {31'd0, done}, {31'd0, e_done});
        chk($sformatf("%s busy",  tag), {31'd0, busy}, {31'd0, e_busy});
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_rows = '0; array_ready = 1'b1;
        tick();
        tick();
        // Reset state, with the FIFO non-empty and rst still high.
        push(32'h0403_0201);
        cyc("RST", 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
        clear_fifo();

        // T1: three rows with no stalls.
        push(32'h0403_0201); push(32'h1413_1211); push(32'h2423_2221);
        cyc("T1c0", 1, 16'd3, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T1c1", 0, 16'd0, 1, 0, 0, 1, 4'b0000, 32'h0000_0000, 0, 1);
        cyc("T1c2", 0, 16'd0, 1, 0, 0, 1, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T1c3", 0, 16'd0, 1, 0, 0, 1, 4'b0011, 32'h0000_0211, 0, 1);
        cyc("T1c4", 0, 16'd0, 1, 0, 0, 0, 4'b0111, 32'h0003_1221, 0, 1);
        cyc("T1c5", 0, 16'd0, 1, 0, 0, 0, 4'b1110, 32'h0413_2200, 0, 1);
        cyc("T1c6", 0, 16'd0, 1, 0, 0, 0, 4'b1100, 32'h1423_0000, 0, 1);
        cyc("T1c7", 0, 16'd0, 1, 0, 0, 0, 4'b1000, 32'h2400_0000, 1, 1);
        cyc("T1c8", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);

        // T2: the FIFO underruns for two cycles after the first pop.
        push(32'h0403_0201); push(32'h1413_1211);
        cyc("T2c0", 1, 16'd2, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T2c1", 0, 16'd0, 1, 0, 0, 1, 4'b0000, 32'h0000_0000, 0, 1);
        cyc("T2c2", 0, 16'd0, 1, 1, 0, 0, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T2c3", 0, 16'd0, 1, 1, 0, 0, 4'b0010, 32'h0000_0200, 0, 1);
        cyc("T2c4", 0, 16'd0, 1, 0, 0, 1, 4'b0100, 32'h0003_0000, 0, 1);
        cyc("T2c5", 0, 16'd0, 1, 0, 0, 0, 4'b1001, 32'h0400_0011, 0, 1);
        cyc("T2c6", 0, 16'd0, 1, 0, 0, 0, 4'b0010, 32'h0000_1200, 0, 1);
        cyc("T2c7", 0, 16'd0, 1, 0, 0, 0, 4'b0100, 32'h0013_0000, 0, 1);
        cyc("T2c8", 0, 16'd0, 1, 0, 0, 0, 4'b1000, 32'h1400_0000, 1, 1);
        cyc("T2c9", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);

        // T3: array_ready is low for three cycles in the middle of the burst.
        push(32'h0403_0201); push(32'h1413_1211); push(32'h2423_2221);
        cyc("T3c0",  1, 16'd3, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T3c1",  0, 16'd0, 1, 0, 0, 1, 4'b0000, 32'h0000_0000, 0, 1);
        cyc("T3c2",  0, 16'd0, 0, 0, 0, 0, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T3c3",  0, 16'd0, 0, 0, 0, 0, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T3c4",  0, 16'd0, 0, 0, 0, 0, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T3c5",  0, 16'd0, 1, 0, 0, 1, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T3c6",  0, 16'd0, 1, 0, 0, 1, 4'b0011, 32'h0000_0211, 0, 1);
        cyc("T3c7",  0, 16'd0, 1, 0, 0, 0, 4'b0111, 32'h0003_1221, 0, 1);
        cyc("T3c8",  0, 16'd0, 1, 0, 0, 0, 4'b1110, 32'h0413_2200, 0, 1);
        cyc("T3c9",  0, 16'd0, 1, 0, 0, 0, 4'b1100, 32'h1423_0000, 0, 1);
        cyc("T3c10", 0, 16'd0, 1, 0, 0, 0, 4'b1000, 32'h2400_0000, 1, 1);
        cyc("T3c11", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);

        // T4: start with num_rows = 0.
        cyc("T4c0", 1, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 0);
        cyc("T4c1", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0, 1, 1);
        cyc("T4c2", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 0);

        // T5: start is ignored while busy, and a third queued row is never popped.
        push(32'h0403_0201); push(32'h1413_1211); push(32'h2423_2221);
        cyc("T5c0", 1, 16'd2, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T5c1", 0, 16'd0, 1, 0, 0, 1, 4'b0000, 32'h0000_0000, 0, 1);
        cyc("T5c2", 1, 16'd5, 1, 0, 0, 1, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T5c3", 1, 16'd7, 1, 0, 0, 0, 4'b0011, 32'h0000_0211, 0, 1);
        cyc("T5c4", 0, 16'd0, 1, 0, 0, 0, 4'b0110, 32'h0003_1200, 0, 1);
        cyc("T5c5", 0, 16'd0, 1, 0, 0, 0, 4'b1100, 32'h0413_0000, 0, 1);
        cyc("T5c6", 1, 16'd9, 1, 0, 0, 0, 4'b1000, 32'h1400_0000, 1, 1);
        cyc("T5c7", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T5c8", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        clear_fifo();

        // T6: reset mid-FEED, then a fresh one-row burst.
        push(32'h0403_0201); push(32'h1413_1211); push(32'h2423_2221);
        cyc("T6c0", 1, 16'd3, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T6c1", 0, 16'd0, 1, 0, 0, 1, 4'b0000, 32'h0000_0000, 0, 1);
        cyc("T6c2", 0, 16'd0, 1, 0, 0, 1, 4'b0001, 32'h0000_0001, 0, 1);
        cyc("T6c3", 0, 16'd0, 1, 0, 1, 0, 4'b0011, 32'h0000_0211, 0, 1);
        cyc("T6c4", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T6c5", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        clear_fifo();
        push(32'h3433_3231);
        cyc("T6r0", 1, 16'd1, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);
        cyc("T6r1", 0, 16'd0, 1, 0, 0, 1, 4'b0000, 32'h0000_0000, 0, 1);
        cyc("T6r2", 0, 16'd0, 1, 0, 0, 0, 4'b0001, 32'h0000_0031, 0, 1);
        cyc("T6r3", 0, 16'd0, 1, 0, 0, 0, 4'b0010, 32'h0000_3200, 0, 1);
        cyc("T6r4", 0, 16'd0, 1, 0, 0, 0, 4'b0100, 32'h0033_0000, 0, 1);
        cyc("T6r5", 0, 16'd0, 1, 0, 0, 0, 4'b1000, 32'h3400_0000, 1, 1);
        cyc("T6r6", 0, 16'd0, 1, 0, 0, 0, 4'b0000, 32'h0000_0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
